id_ex_stage: RTL and testbench

Pipeline register and operand-forwarding stage between instruction decode and the 32-bit ALU. Captures decoded operands and ALU controls each cycle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU's `src1`/`src2`/`ALU_control`/`bonus_control` inputs directly. Supports a stall (hold) and a flush (bubble), and keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage_if.sv | 31 +++
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID-to-EX decoded instruction bundle.
// Decode drives master, the EX stage receives on slave.
interface id_ex_stage_if;
  logic        id_valid_i;
  logic [31:0] id_rs_data_i;
  logic [31:0] id_rt_data_i;
  logic [31:0] id_imm_i;
  logic [4:0]  id_rs_addr_i;
  logic [4:0]  id_rt_addr_i;
  logic [4:0]  id_rd_addr_i;
  logic [3:0]  id_alu_control_i;
  logic [2:0]  id_bonus_control_i;
  logic        id_alu_src_i;
  logic        id_reg_write_i;

  modport master (
    output id_valid_i, id_rs_data_i, id_rt_data_i,
    output id_imm_i, id_rs_addr_i, id_rt_addr_i,
    output id_rd_addr_i, id_alu_control_i,
    output id_bonus_control_i, id_alu_src_i,
    output id_reg_write_i
  );

  modport slave (
    input id_valid_i, id_rs_data_i, id_rt_data_i,
    input id_imm_i, id_rs_addr_i, id_rt_addr_i,
    input id_rd_addr_i, id_alu_control_i,
    input id_bonus_control_i, id_alu_src_i,
    input id_reg_write_i
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand
// forwarding into the ALU, stall refresh, flush and bubble counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  id_ex_stage_if.slave      id,
  input  logic              exmem_reg_write_i,
  input  logic [4:0]        exmem_rd_i,
  input  logic [31:0]       exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [4:0]        memwb_rd_i,
  input  logic [31:0]       memwb_result_i,
  output logic              ex_valid_o,
  output logic [31:0]       src1_o,
  output logic [31:0]       src2_o,
  output logic [3:0]        alu_control_o,
  output logic [2:0]        bonus_control_o,
  output logic [31:0]       ex_rt_data_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_reg_write_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_control;
    logic [2:0]  bonus_control;
    logic        alu_src;
    logic        reg_write;
  } id_ex_t;

  id_ex_t           ex_q;
  id_ex_t           id_d;
  logic [31:0]      fwd_rs;
  logic [31:0]      fwd_rt;
  logic             em_rs, em_rt, mw_rs, mw_rt;
  logic [CNT_W-1:0] cnt_q;

  // Pack the incoming decode bundle.
  always_comb begin
    id_d               = '0;
    id_d.valid         = id.id_valid_i;
    id_d.rs_data       = id.id_rs_data_i;
    id_d.rt_data       = id.id_rt_data_i;
    id_d.imm           = id.id_imm_i;
    id_d.rs_addr       = id.id_rs_addr_i;
    id_d.rt_addr       = id.id_rt_addr_i;
    id_d.rd_addr       = id.id_rd_addr_i;
    id_d.alu_control   = id.id_alu_control_i;
    id_d.bonus_control = id.id_bonus_control_i;
    id_d.alu_src       = id.id_alu_src_i;
    id_d.reg_write     = id.id_reg_write_i;
  end

  // Hazard match; $0 and bubbles never forward.
  always_comb begin
    em_rs = ex_q.valid && exmem_reg_write_i
         && (exmem_rd_i == ex_q.rs_addr)
         && (ex_q.rs_addr != 5'd0);
    em_rt = ex_q.valid && exmem_reg_write_i
         && (exmem_rd_i == ex_q.rt_addr)
         && (ex_q.rt_addr != 5'd0);
    mw_rs = ex_q.valid && memwb_reg_write_i
         && (memwb_rd_i == ex_q.rs_addr)
         && (ex_q.rs_addr != 5'd0);
    mw_rt = ex_q.valid && memwb_reg_write_i
         && (memwb_rd_i == ex_q.rt_addr)
         && (ex_q.rt_addr != 5'd0);
  end

  // rs operand select, younger producer first.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    unique case (1'b1)
      em_rs:           fwd_rs = exmem_result_i;
      mw_rs && !em_rs: fwd_rs = memwb_result_i;
      default:         fwd_rs = ex_q.rs_data;
    endcase
  end

  // rt operand select, younger producer first.
  always_comb begin
    fwd_rt = ex_q.rt_data;
    unique case (1'b1)
      em_rt:           fwd_rt = exmem_result_i;
      mw_rt && !em_rt: fwd_rt = memwb_result_i;
      default:         fwd_rt = ex_q.rt_data;
    endcase
  end

  // EX register: flush beats stall; stall latches forwarded data.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (stall_i) begin
      ex_q.rs_data <= ex_q.valid ? fwd_rs : 32'd0;
      ex_q.rt_data <= ex_q.valid ? fwd_rt : 32'd0;
    end else begin
      ex_q <= id_d;
    end
  end

  // Saturating count of unstalled bubble cycles.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!ex_q.valid && !stall_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign src1_o          = fwd_rs;
  assign src2_o          = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign alu_control_o   = ex_q.alu_control;
  assign bonus_control_o = ex_q.bonus_control;
  assign ex_rt_data_o    = fwd_rt;
  assign ex_rd_o         = ex_q.rd_addr;
  assign ex_reg_write_o  = ex_q.reg_write & ex_q.valid;
  assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a queue scoreboard.
// CNT_W=2 so counter saturation is reachable.
module tb_id_ex_stage;
  localparam int CNT_W = 2;

  typedef struct {
    logic        v;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  ac;
    logic [2:0]  bc;
    logic [31:0] rtd;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  cnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;
  logic exmem_reg_write_i = 1'b0;
  logic [4:0] exmem_rd_i = '0;
  logic [31:0] exmem_result_i = '0;
  logic memwb_reg_write_i = 1'b0;
  logic [4:0] memwb_rd_i = '0;
  logic [31:0] memwb_result_i = '0;
  logic ex_valid_o;
  logic [31:0] src1_o, src2_o, ex_rt_data_o;
  logic [3:0] alu_control_o;
  logic [2:0] bonus_control_o;
  logic [4:0] ex_rd_o;
  logic ex_reg_write_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  id_ex_stage_if id_bus ();

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .id(id_bus.slave),
    .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i),
    .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i),
    .memwb_result_i(memwb_result_i),
    .ex_valid_o(ex_valid_o), .src1_o(src1_o), .src2_o(src2_o),
    .alu_control_o(alu_control_o),
    .bonus_control_o(bonus_control_o),
    .ex_rt_data_o(ex_rt_data_o), .ex_rd_o(ex_rd_o),
    .ex_reg_write_o(ex_reg_write_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input int step,
                     input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s step%0d got=%h want=%h", n, step, a, e);
    end
  endtask

  // Monitor: every sampled cycle with a pending entry is checked.
  int mstep = 0;
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("valid", mstep, 32'(ex_valid_o), 32'(e.v));
      chk("src1", mstep, src1_o, e.s1);
      chk("src2", mstep, src2_o, e.s2);
      chk("alu_ctl", mstep, 32'(alu_control_o), 32'(e.ac));
      chk("bonus", mstep, 32'(bonus_control_o), 32'(e.bc));
      chk("rt_data", mstep, ex_rt_data_o, e.rtd);
      chk("rd", mstep, 32'(ex_rd_o), 32'(e.rd));
      chk("reg_wr", mstep, 32'(ex_reg_write_o), 32'(e.rw));
      chk("bub_cnt", mstep, 32'(bubble_cnt_o), 32'(e.cnt));
      mstep++;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm,
                        input logic [4:0] rsa, input logic [4:0] rta,
                        input logic [4:0] rda, input logic [3:0] ac,
                        input logic [2:0] bc, input logic asrc,
                        input logic rw);
    id_bus.id_valid_i = v;
    id_bus.id_rs_data_i = rs;
    id_bus.id_rt_data_i = rt;
    id_bus.id_imm_i = imm;
    id_bus.id_rs_addr_i = rsa;
    id_bus.id_rt_addr_i = rta;
    id_bus.id_rd_addr_i = rda;
    id_bus.id_alu_control_i = ac;
    id_bus.id_bonus_control_i = bc;
    id_bus.id_alu_src_i = asrc;
    id_bus.id_reg_write_i = rw;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd,
                         input logic [31:0] eres, input logic mw,
                         input logic [4:0] mrd, input logic [31:0] mres);
    exmem_reg_write_i = ew;
    exmem_rd_i = erd;
    exmem_result_i = eres;
    memwb_reg_write_i = mw;
    memwb_rd_i = mrd;
    memwb_result_i = mres;
  endtask

  task automatic expect_o(input logic v, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [3:0] ac,
                          input logic [2:0] bc, input logic [31:0] rtd,
                          input logic [4:0] rd, input logic rw,
                          input logic [1:0] cnt);
    exp_t e;
    e.v = v; e.s1 = s1; e.s2 = s2; e.ac = ac; e.bc = bc;
    e.rtd = rtd; e.rd = rd; e.rw = rw; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic id_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 4'h0, 3'h0, 0, 0);
  endtask

  initial begin
    id_idle();
    // S0: reset held from time 0
    step();
    expect_o(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0);
    rst_n = 1'b1;
    // S1: first bubble counted
    step();
    expect_o(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd1);
    set_id(1, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3, 4'b0010, 0, 0, 1);
    // S2: plain pass-through
    step();
    expect_o(1, 32'd5, 32'd7, 4'b0010, 0, 32'd7, 5'd3, 1, 2'd2);
    set_id(1, 32'h100, 32'h200, 0, 5'd4, 5'd5, 5'd6,
           4'b0110, 0, 0, 1);
    // S3: both sources write r4, EX/MEM wins
    step();
    set_fwd(1, 5'd4, 32'h11, 1, 5'd4, 32'h22);
    expect_o(1, 32'h11, 32'h200, 4'b0110, 0, 32'h200, 5'd6, 1, 2'd2);
    // S4: only MEM/WB writes r4
    step();
    set_fwd(0, 5'd4, 32'h11, 1, 5'd4, 32'h22);
    expect_o(1, 32'h22, 32'h200, 4'b0110, 0, 32'h200, 5'd6, 1, 2'd2);
    set_id(1, 32'h100, 32'h200, 0, 5'd0, 5'd5, 5'd6,
           4'b0110, 0, 0, 1);
    // S5: rs = $0 never forwarded
    step();
    set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    expect_o(1, 32'h100, 32'h200, 4'b0110, 0, 32'h200, 5'd6, 1, 2'd2);
    set_id(1, 32'h3, 32'h1, 32'hFFFF_FFFC, 5'd7, 5'd8, 5'd9,
           4'b0010, 3'b101, 1, 0);
    // S6: immediate select, rt forwarded to store data
    step();
    set_fwd(1, 5'd8, 32'h9, 0, 5'd0, 0);
    expect_o(1, 32'h3, 32'hFFFF_FFFC, 4'b0010, 3'b101, 32'h9,
             5'd9, 0, 2'd2);
    set_id(1, 32'h10, 32'h55, 0, 5'd1, 5'd2, 5'd10,
           4'b0001, 0, 0, 1);
    // S7: first stall cycle, MEM/WB writes r2
    step();
    set_fwd(0, 5'd0, 0, 1, 5'd2, 32'hAB);
    stall_i = 1'b1;
    expect_o(1, 32'h10, 32'hAB, 4'b0001, 0, 32'hAB, 5'd10, 1, 2'd2);
    set_id(1, 32'h20, 32'h30, 0, 5'd11, 5'd12, 5'd13,
           4'b0011, 0, 0, 1);
    // S8, S9: producer gone, refreshed value held
    step();
    set_fwd(0, 5'd0, 0, 1, 5'd9, 32'hCD);
    expect_o(1, 32'h10, 32'hAB, 4'b0001, 0, 32'hAB, 5'd10, 1, 2'd2);
    step();
    expect_o(1, 32'h10, 32'hAB, 4'b0001, 0, 32'hAB, 5'd10, 1, 2'd2);
    // S10: release, still shows refreshed operands
    step();
    stall_i = 1'b0;
    expect_o(1, 32'h10, 32'hAB, 4'b0001, 0, 32'hAB, 5'd10, 1, 2'd2);
    // S11: next instruction advanced
    step();
    set_fwd(0, 0, 0, 0, 0, 0);
    expect_o(1, 32'h20, 32'h30, 4'b0011, 0, 32'h30, 5'd13, 1, 2'd2);
    flush_i = 1'b1;
    stall_i = 1'b1;
    // S12: flush+stall, counter holds at 2
    step();
    flush_i = 1'b0;
    stall_i = 1'b0;
    expect_o(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd2);
    set_id(0, 32'h5, 32'h6, 0, 5'd2, 5'd3, 5'd0, 4'h0, 0, 0, 0);
    // S13: invalid entry, forwarding disabled, count 3
    step();
    set_fwd(1, 5'd2, 32'hEE, 1, 5'd3, 32'hDD);
    expect_o(0, 32'h5, 32'h6, 4'h0, 0, 32'h6, 0, 0, 2'd3);
    stall_i = 1'b1;
    id_idle();
    // S14: stalled bubble refreshes to zeros, count saturated
    step();
    expect_o(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd3);
    stall_i = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    // S15: still saturated
    step();
    expect_o(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd3);
    set_id(1, 32'h77, 32'h88, 0, 5'd3, 5'd4, 5'd5,
           4'b0111, 3'b010, 0, 1);
    // S16: valid state loaded
    step();
    expect_o(1, 32'h77, 32'h88, 4'b0111, 3'b010, 32'h88,
             5'd5, 1, 2'd3);
    // S17: async reset mid-cycle, checked before the next edge
    step();
    rst_n = 1'b0;
    id_idle();
    expect_o(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0);
    step();
    expect_o(0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0);
    rst_n = 1'b1;
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
